ex_muldiv_unit: RTL and testbench



---
 rtl/ex_muldiv_unit.sv | 181 ++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative EX-stage multiply/divide unit with HI/LO registers; stalls ID/EX while a mul/div runs.
// Divider datapath is present only when MULDIV_DIV_EN is defined.
module ex_muldiv_unit (
  input  logic        clock,
  input  logic        rst,
  input  logic [5:0]  aluControl,
  input  logic [31:0] DataA,
  input  logic [31:0] DataB,
  output logic        IDEXWrite,
  output logic        busy,
  output logic [31:0] result,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [5:0] OP_MFHI  = 6'h10;
  localparam logic [5:0] OP_MTHI  = 6'h11;
  localparam logic [5:0] OP_MFLO  = 6'h12;
  localparam logic [5:0] OP_MTLO  = 6'h13;
  localparam logic [5:0] OP_MULT  = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19;
  localparam logic [5:0] OP_DIV   = 6'h1A;
  localparam logic [5:0] OP_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  state_t      state_r, state_s;
  logic [4:0]  cnt_r;
  logic [63:0] acc_r;
  logic [31:0] opnd_r;
  logic        is_div_r;
  logic        neg_lo_r;
  logic        neg_hi_r;
  logic [31:0] hi_r, lo_r;

  logic        is_mul_s, is_div_s, start_s, sgn_op_s, a_neg_s, b_neg_s;
  logic [31:0] mag_a_s, mag_b_s;
  logic [32:0] sum_s;
  logic [63:0] mul_nxt_s, acc_nxt_s, mul_res_s;
  logic [31:0] hi_fin_s, lo_fin_s;

  assign is_mul_s = (aluControl == OP_MULT) || (aluControl == OP_MULTU);
`ifdef MULDIV_DIV_EN
  assign is_div_s = (aluControl == OP_DIV) || (aluControl == OP_DIVU);
`else
  assign is_div_s = 1'b0;
`endif
  assign start_s  = is_mul_s | is_div_s;
  assign sgn_op_s = (aluControl == OP_MULT) || (aluControl == OP_DIV);
  assign a_neg_s  = sgn_op_s & DataA[31];
  assign b_neg_s  = sgn_op_s & DataB[31];
  assign mag_a_s  = a_neg_s ? neg32(DataA) : DataA;
  assign mag_b_s  = b_neg_s ? neg32(DataB) : DataB;

  // Shift-add step: multiplier sits in the low half and shifts out as the product shifts in.
  assign sum_s     = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opnd_r} : 33'd0);
  assign mul_nxt_s = {sum_s, acc_r[31:1]};

`ifdef MULDIV_DIV_EN
  logic        ge_s;
  logic [31:0] sub_s;
  logic [63:0] div_nxt_s;
  assign ge_s      = acc_r[63:31] >= {1'b0, opnd_r};
  assign sub_s     = acc_r[62:31] - opnd_r;
  assign div_nxt_s = ge_s ? {sub_s, acc_r[30:0], 1'b1} : {acc_r[62:0], 1'b0};
  assign acc_nxt_s = is_div_r ? div_nxt_s : mul_nxt_s;
`else
  assign acc_nxt_s = mul_nxt_s;
`endif

  assign mul_res_s = neg_lo_r ? neg64(acc_nxt_s) : acc_nxt_s;
  assign hi_fin_s  = is_div_r ? (neg_hi_r ? neg32(acc_nxt_s[63:32]) : acc_nxt_s[63:32])
                              : mul_res_s[63:32];
  assign lo_fin_s  = is_div_r ? (neg_lo_r ? neg32(acc_nxt_s[31:0]) : acc_nxt_s[31:0])
                              : mul_res_s[31:0];

  // State register
  always_ff @(posedge clock) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and pipeline stall decode
  always_comb begin
    state_s   = state_r;
    IDEXWrite = 1'b1;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_s   = ST_BUSY;
          IDEXWrite = 1'b0;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_BUSY: begin
        IDEXWrite = 1'b0;
        if (cnt_r == 5'd31) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_BUSY;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Operand latch, iteration datapath and HI/LO registers
  always_ff @(posedge clock) begin
    if (rst) begin
      cnt_r    <= 5'd0;
      acc_r    <= 64'd0;
      opnd_r   <= 32'd0;
      is_div_r <= 1'b0;
      neg_lo_r <= 1'b0;
      neg_hi_r <= 1'b0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            cnt_r    <= 5'd0;
            is_div_r <= is_div_s;
            acc_r    <= {32'd0, (is_div_s ? mag_a_s : mag_b_s)};
            opnd_r   <= is_div_s ? mag_b_s : mag_a_s;
            // A zero divisor keeps the all-ones quotient and lets the remainder rebuild DataA.
            neg_lo_r <= (a_neg_s ^ b_neg_s) & (~is_div_s | (|DataB));
            neg_hi_r <= is_div_s & a_neg_s;
          end else if (aluControl == OP_MTHI) begin
            hi_r <= DataA;
          end else if (aluControl == OP_MTLO) begin
            lo_r <= DataA;
          end
        end
        ST_BUSY: begin
          cnt_r <= cnt_r + 5'd1;
          acc_r <= acc_nxt_s;
          if (cnt_r == 5'd31) begin
            hi_r <= hi_fin_s;
            lo_r <= lo_fin_s;
          end
        end
        default: begin
          cnt_r <= 5'd0;
        end
      endcase
    end
  end

  // MFHI/MFLO read mux
  always_comb begin
    result = 32'd0;
    case (aluControl)
      OP_MFHI: result = hi_r;
      OP_MFLO: result = lo_r;
      default: result = 32'd0;
    endcase
  end

  assign busy = (state_r == ST_BUSY);
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed, table-driven bench for ex_muldiv_unit: mul/div vectors, stall length, MT/MF, reset abort.
module tb_ex_muldiv_unit;

  logic        clock = 1'b0;
  logic        rst;
  logic [5:0]  aluControl;
  logic [31:0] DataA, DataB;
  logic        IDEXWrite, busy;
  logic [31:0] result, hi, lo;

  localparam logic [5:0] NOP   = 6'h00;
  localparam logic [5:0] MFHI  = 6'h10;
  localparam logic [5:0] MTHI  = 6'h11;
  localparam logic [5:0] MFLO  = 6'h12;
  localparam logic [5:0] MTLO  = 6'h13;
  localparam logic [5:0] MULT  = 6'h18;
  localparam logic [5:0] MULTU = 6'h19;
  localparam logic [5:0] DIV   = 6'h1A;
  localparam logic [5:0] DIVU  = 6'h1B;

  ex_muldiv_unit dut (
    .clock(clock), .rst(rst), .aluControl(aluControl), .DataA(DataA), .DataB(DataB),
    .IDEXWrite(IDEXWrite), .busy(busy), .result(result), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[16];
  int   nvec  = 0;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo);
    vecs[nvec] = '{op, a, b, ehi, elo};
    nvec++;
  endtask

  // Issue one mul/div, count stall cycles, check HI/LO at DONE, then read back via MFHI/MFLO.
  task automatic run_md(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int stalls;
    stalls = 0;
    @(posedge clock); #1;
    aluControl = op; DataA = a; DataB = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (i == 0) chk("busy_at_issue", {31'd0, busy}, 32'd0);
      if (i == 1) begin
        chk("busy_in_busy", {31'd0, busy}, 32'd1);
        DataA = 32'hDEADBEEF;
        DataB = 32'h0BADF00D;
      end
      if (IDEXWrite) break;
      stalls++;
    end
    chk("stall_cycles", stalls, 32'd33);
    chk("hi_at_done", hi, ehi);
    chk("lo_at_done", lo, elo);
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    @(posedge clock); #1;
    aluControl = MFHI;
    @(negedge clock);
    chk("mfhi_after_op", result, ehi);
    chk("no_restall_mfhi", {31'd0, IDEXWrite}, 32'd1);
    @(posedge clock); #1;
    aluControl = MFLO;
    @(negedge clock);
    chk("mflo_after_op", result, elo);
    @(posedge clock); #1;
    aluControl = NOP;
  endtask

  initial begin
    rst = 1'b1; aluControl = NOP; DataA = 32'd0; DataB = 32'd0;

    add_vec(MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE);
    add_vec(MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB);
    add_vec(MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    add_vec(MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780);
    add_vec(MULT,  32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB);
    add_vec(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
`ifdef MULDIV_DIV_EN
    add_vec(DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    add_vec(DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF);
    add_vec(DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    add_vec(DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF);
    add_vec(DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E);
    add_vec(DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
`endif

    repeat (3) @(posedge clock);
    #1 rst = 1'b0;
    @(negedge clock);
    chk("rst_idexwrite", {31'd0, IDEXWrite}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    @(posedge clock); #1;
    aluControl = MTHI; DataA = 32'hA5A5A5A5;
    @(negedge clock);
    chk("mthi_no_stall", {31'd0, IDEXWrite}, 32'd1);
    chk("mthi_result_zero", result, 32'd0);
    @(posedge clock); #1;
    aluControl = MFHI; DataA = 32'd0;
    @(negedge clock);
    chk("mfhi_after_mthi", result, 32'hA5A5A5A5);
    @(posedge clock); #1;
    aluControl = MTLO; DataA = 32'h5A5A5A5A;
    @(negedge clock);
    chk("hi_kept_by_mtlo", hi, 32'hA5A5A5A5);
    @(posedge clock); #1;
    aluControl = MFLO;
    @(negedge clock);
    chk("mflo_after_mtlo", result, 32'h5A5A5A5A);
    @(posedge clock); #1;
    aluControl = NOP;

    for (int v = 0; v < nvec; v++) begin
      run_md(vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].ehi, vecs[v].elo);
    end

`ifndef MULDIV_DIV_EN
    @(posedge clock); #1;
    aluControl = MTHI; DataA = 32'h11111111;
    @(posedge clock); #1;
    aluControl = MTLO; DataA = 32'h22222222;
    @(posedge clock); #1;
    aluControl = DIV; DataA = 32'd10; DataB = 32'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("nodiv_idexwrite", {31'd0, IDEXWrite}, 32'd1);
      chk("nodiv_busy", {31'd0, busy}, 32'd0);
    end
    @(posedge clock); #1;
    aluControl = DIVU;
    @(negedge clock);
    chk("nodivu_idexwrite", {31'd0, IDEXWrite}, 32'd1);
    chk("nodiv_hi", hi, 32'h11111111);
    chk("nodiv_lo", lo, 32'h22222222);
    @(posedge clock); #1;
    aluControl = NOP;
`endif

    // Abort a multiply part-way through: reset lands while the counter reads 10.
    @(posedge clock); #1;
    aluControl = MTHI; DataA = 32'h33333333;
    @(posedge clock); #1;
    aluControl = MULTU; DataA = 32'hFFFFFFFF; DataB = 32'hFFFFFFFF;
    repeat (11) @(posedge clock);
    #1;
    chk("busy_before_abort", {31'd0, busy}, 32'd1);
    rst = 1'b1; aluControl = NOP;
    @(posedge clock); #1;
    rst = 1'b0;
    @(negedge clock);
    chk("abort_idexwrite", {31'd0, IDEXWrite}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    run_md(MULTU, 32'd3, 32'd4, 32'd0, 32'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
